// File: rtl/lcla_word_sequencer_if.sv
// Operand, adder-slice and result signals of lcla_word_sequencer.
// Defining LCLA_SEQ_OVF_EN adds the signed-overflow flag Ovf_out.
interface lcla_word_sequencer_if #(
    parameter int unsigned WORDS = 4
);
    logic                  Start_in;
    logic [16*WORDS-1:0]   A_in;
    logic [16*WORDS-1:0]   B_in;
    logic                  C_in;
    logic                  Ready_out;
    logic [15:0]           Add_A_out;
    logic [15:0]           Add_B_out;
    logic                  Add_C_out;
    logic [15:0]           Add_S_in;
    logic                  Add_C_in;
    logic [16*WORDS-1:0]   S_out;
    logic                  C_out;
    logic                  Valid_out;
`ifdef LCLA_SEQ_OVF_EN
    logic                  Ovf_out;
`endif

    modport master (
        output Start_in, A_in, B_in, C_in, Add_S_in, Add_C_in,
`ifdef LCLA_SEQ_OVF_EN
        input  Ovf_out,
`endif
        input  Ready_out, Add_A_out, Add_B_out, Add_C_out, S_out, C_out, Valid_out
    );

    modport slave (
        input  Start_in, A_in, B_in, C_in, Add_S_in, Add_C_in,
`ifdef LCLA_SEQ_OVF_EN
        output Ovf_out,
`endif
        output Ready_out, Add_A_out, Add_B_out, Add_C_out, S_out, C_out, Valid_out
    );
endinterface

// File: rtl/lcla_word_sequencer.sv
// Feeds a WORDS x 16-bit add through an external 16-bit adder, one slice per cycle, LSB first.
// Optional feature macro: LCLA_SEQ_OVF_EN (adds signed-overflow output Ovf_out).
module lcla_word_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  Clk_in,
    input  logic                  Rst_n_in,
    lcla_word_sequencer_if.slave  bus
);
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic [WORDS-1:0][15:0]   a_q, a_d;
    logic [WORDS-1:0][15:0]   b_q, b_d;
    logic [WORDS-1:0][15:0]   s_q, s_d;
    logic                     c_q, c_d;
`ifdef LCLA_SEQ_OVF_EN
    logic                     ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
`ifdef LCLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.Start_in) begin
                    a_d     = bus.A_in;
                    b_d     = bus.B_in;
                    carry_d = bus.C_in;
                    idx_d   = '0;
                    s_d     = '0;
                    c_d     = 1'b0;
`ifdef LCLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d[idx_q] = bus.Add_S_in;
                carry_d    = bus.Add_C_in;
                if (idx_q == LastIdx) begin
                    c_d     = bus.Add_C_in;
                    idx_d   = '0;
`ifdef LCLA_SEQ_OVF_EN
                    // Top slice's sum MSB is the full-width sum MSB.
                    ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                              (bus.Add_S_in[15] != a_q[WORDS-1][15]);
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
`ifdef LCLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
`ifdef LCLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        bus.Add_A_out = '0;
        bus.Add_B_out = '0;
        bus.Add_C_out = 1'b0;
        if (state_q == StRun) begin
            bus.Add_A_out = a_q[idx_q];
            bus.Add_B_out = b_q[idx_q];
            bus.Add_C_out = carry_q;
        end
    end

    assign bus.Ready_out = (state_q == StIdle);
    assign bus.Valid_out = (state_q == StDone);
    assign bus.S_out     = s_q;
    assign bus.C_out     = c_q;
`ifdef LCLA_SEQ_OVF_EN
    assign bus.Ovf_out   = ovf_q;
`endif
endmodule

// File: tb/tb_lcla_word_sequencer.sv
// Directed bench for lcla_word_sequencer at WORDS=4 and WORDS=1, with a behavioural 16-bit adder.
module tb_lcla_word_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    lcla_word_sequencer_if #(.WORDS(4)) bus4 ();
    lcla_word_sequencer_if #(.WORDS(1)) bus1 ();

    lcla_word_sequencer #(.WORDS(4)) u_dut4 (.Clk_in(clk), .Rst_n_in(rst_n), .bus(bus4));
    lcla_word_sequencer #(.WORDS(1)) u_dut1 (.Clk_in(clk), .Rst_n_in(rst_n), .bus(bus1));

    // Stand-in for the combinational LCLA_16 adder.
    assign {bus4.Add_C_in, bus4.Add_S_in} = {1'b0, bus4.Add_A_out} + {1'b0, bus4.Add_B_out}
                                            + {16'b0, bus4.Add_C_out};
    assign {bus1.Add_C_in, bus1.Add_S_in} = {1'b0, bus1.Add_A_out} + {1'b0, bus1.Add_B_out}
                                            + {16'b0, bus1.Add_C_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accepts one add; returns Add_C_out per presented slice and accept-to-Valid latency.
    task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic c,
                        output logic [3:0] carries, output int lat);
        bus4.A_in     = a;
        bus4.B_in     = b;
        bus4.C_in     = c;
        bus4.Start_in = 1'b1;
        step();
        bus4.Start_in = 1'b0;
        carries       = '0;
        carries[0]    = bus4.Add_C_out;
        lat           = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k < 4) carries[k] = bus4.Add_C_out;
            if (bus4.Valid_out) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] carries;
        int         lat;
        int         rk;
        logic       saw_valid;

        rst_n = 1'b0;
        bus4.Start_in = 1'b0; bus4.A_in = '0; bus4.B_in = '0; bus4.C_in = 1'b0;
        bus1.Start_in = 1'b0; bus1.A_in = '0; bus1.B_in = '0; bus1.C_in = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", bus4.Ready_out, 1);
        chk("rst_valid", bus4.Valid_out, 0);
        chk("rst_s",     bus4.S_out, 0);
        chk("rst_c",     bus4.C_out, 0);
        chk("rst_add_a", bus4.Add_A_out, 0);
        chk("rst_add_c", bus4.Add_C_out, 0);

        // 0xFFFF + 1: carry out of slice 0 into slice 1
        run4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, carries, lat);
        chk("t1_lat",     lat, 5);
        chk("t1_s",       bus4.S_out, 64'h0000_0000_0001_0000);
        chk("t1_c",       bus4.C_out, 0);
        chk("t1_carries", carries, 4'b0010);
        chk("t1_ready",   bus4.Ready_out, 0);
`ifdef LCLA_SEQ_OVF_EN
        chk("t1_ovf",     bus4.Ovf_out, 0);
`endif
        step();
        chk("t1_valid_1cyc", bus4.Valid_out, 0);
        chk("t1_ready_back", bus4.Ready_out, 1);
        chk("t1_s_hold",     bus4.S_out, 64'h0000_0000_0001_0000);
        chk("t1_add_a_idle", bus4.Add_A_out, 0);

        // all-ones + 1: full ripple, carry out
        run4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, carries, lat);
        chk("t2_lat",     lat, 5);
        chk("t2_s",       bus4.S_out, 0);
        chk("t2_c",       bus4.C_out, 1);
        chk("t2_carries", carries, 4'b1110);
        step();

        // carry-in only
        run4(64'h0, 64'h0, 1'b1, carries, lat);
        chk("t3_s",       bus4.S_out, 64'h1);
        chk("t3_c",       bus4.C_out, 0);
        chk("t3_carries", carries, 4'b0001);
        step();

        // signed overflow case
        run4(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, carries, lat);
        chk("t4_s",       bus4.S_out, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t4_c",       bus4.C_out, 0);
        chk("t4_carries", carries, 4'b1110);
`ifdef LCLA_SEQ_OVF_EN
        chk("t4_ovf",     bus4.Ovf_out, 1);
`endif
        step();

        // Start pulsed mid-RUN with other operands must be ignored
        bus4.A_in = 64'h5; bus4.B_in = 64'h6; bus4.C_in = 1'b0; bus4.Start_in = 1'b1;
        step();
        bus4.Start_in = 1'b0;
        step();
        bus4.A_in = 64'h100; bus4.B_in = 64'h200; bus4.Start_in = 1'b1;
        step();
        bus4.Start_in = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus4.Valid_out) begin
                saw_valid = 1'b1;
                break;
            end
            step();
        end
        chk("t5_valid_seen", saw_valid, 1);
        chk("t5_s",          bus4.S_out, 64'hB);
        step();
        chk("t5_no_requeue", bus4.Ready_out, 1);

        // Start held high: re-accept on first IDLE edge, 6 cycles apart
        bus4.A_in = 64'h1; bus4.B_in = 64'h2; bus4.C_in = 1'b0; bus4.Start_in = 1'b1;
        step();
        chk("t6_busy", bus4.Ready_out, 0);
        bus4.A_in = 64'h7;
        rk = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus4.Valid_out) chk("t6_first_s", bus4.S_out, 64'h3);
            if (bus4.Ready_out) begin
                rk = k;
                break;
            end
        end
        chk("t6_ready_edge", rk, 5);
        step();
        bus4.Start_in = 1'b0;
        chk("t6_reaccept",   bus4.Ready_out, 0);
        chk("t6_reaccept_a", bus4.Add_A_out, 16'h0007);
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus4.Valid_out) begin
                saw_valid = 1'b1;
                break;
            end
        end
        chk("t6_valid_seen", saw_valid, 1);
        chk("t6_second_s",   bus4.S_out, 64'h9);
        step();

        // Reset while slice 2 is on the adder
        bus4.A_in = 64'hFFFF_FFFF_FFFF_FFFF; bus4.B_in = 64'h1; bus4.C_in = 1'b0;
        bus4.Start_in = 1'b1;
        step();
        bus4.Start_in = 1'b0;
        step();
        step();
        chk("t7_slice2_c", bus4.Add_C_out, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_ready", bus4.Ready_out, 1);
        chk("t7_rst_add_a", bus4.Add_A_out, 0);
        step();
        step();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            saw_valid = saw_valid | bus4.Valid_out;
        end
        chk("t7_no_valid", saw_valid, 0);
        chk("t7_ready",    bus4.Ready_out, 1);
        chk("t7_s",        bus4.S_out, 0);
        chk("t7_c",        bus4.C_out, 0);
        run4(64'h1, 64'h1, 1'b0, carries, lat);
        chk("t7_after_lat", lat, 5);
        chk("t7_after_s",   bus4.S_out, 64'h2);
        step();

        // WORDS=1 instance
        bus1.A_in = 16'hFFFF; bus1.B_in = 16'h0001; bus1.C_in = 1'b1; bus1.Start_in = 1'b1;
        step();
        bus1.Start_in = 1'b0;
        chk("w1_add_c", bus1.Add_C_out, 1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus1.Valid_out) begin
                lat = k + 1;
                break;
            end
        end
        chk("w1_lat", lat, 2);
        chk("w1_s",   bus1.S_out, 16'h0001);
        chk("w1_c",   bus1.C_out, 1);
        step();
        chk("w1_valid_1cyc", bus1.Valid_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
